// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: generator states,
// maximal-length LFSR tap masks and the scale-word width.
package sc_pkg;

    localparam int unsigned SC_NUMMAX_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_gen_state_t;

    // Tap mask (bit i set => lfsr[i] feeds the XOR) for a left-shifting Fibonacci LFSR.
    function automatic logic [8:0] sc_lfsr_taps(input int unsigned width);
        logic [8:0] mask;
        case (width)
            4:       mask = 9'h00C;
            5:       mask = 9'h014;
            6:       mask = 9'h030;
            7:       mask = 9'h060;
            8:       mask = 9'h0B8;
            9:       mask = 9'h110;
            default: mask = 9'h0B8;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous reload to a non-zero seed.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam int unsigned     SEED_LO = SEED % (2 ** WIDTH);
    // An all-zero seed would lock the register, so it is mapped to 1.
    localparam logic [WIDTH-1:0] SEED_W = (SEED_LO == 0) ? WIDTH'(1) : WIDTH'(SEED_LO);
    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(sc_lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_lfsr;
    logic             w_fb;

    assign w_fb = ^(r_lfsr & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED_W;
        end else if (load) begin
            r_lfsr <= SEED_W;
        end else if (step) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], w_fb};
        end
    end

    assign state = r_lfsr;

endmodule

// File: rtl/sc_bitstream_gen.sv
// Stochastic number generator: emits a 2^WIDTH-1 bit unipolar stream whose
// ones count equals the captured operand, by comparing an LFSR against it.
module sc_bitstream_gen
    import sc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEED  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       value,
    input  logic [SC_NUMMAX_W-1:0] nummax_in,
    input  logic                   en,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic [SC_NUMMAX_W-1:0] nummax,
    output logic                   busy,
    output logic                   done
);

    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'((2 ** WIDTH) - 2);

    sc_gen_state_t          r_state;
    sc_gen_state_t          w_state_nxt;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_value_q;
    logic [SC_NUMMAX_W-1:0] r_nummax;
    logic [WIDTH-1:0]       w_lfsr;
    logic                   w_accept;
    logic                   w_step;

    assign w_accept = (r_state == IDLE) && start;
    assign w_step   = (r_state == RUN) && en;

    sc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .step  (w_step),
        .state (w_lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (en && (r_cnt == LAST_CNT)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_value_q <= '0;
            r_nummax  <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_value_q <= value;
            r_nummax  <= nummax_in;
        end else if (w_step) begin
            r_cnt     <= r_cnt + WIDTH'(1);
        end
    end

    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            RUN: begin
                busy      = 1'b1;
                bit_valid = en;
                bit_out   = (w_lfsr <= r_value_q);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign nummax = r_nummax;

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Self-checking bench for sc_bitstream_gen (WIDTH=8, SEED=1) against a
// reference stream built from the maximal-length sequence and ones-count rule.
module tb_sc_bitstream_gen;

    localparam int unsigned W   = 8;
    localparam int          LEN = 255;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] value;
    logic [8:0]   nummax_in;
    logic         en;
    logic         bit_out;
    logic         bit_valid;
    logic [8:0]   nummax;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    int seq [LEN];
    logic g_first [5];

    sc_bitstream_gen #(
        .WIDTH (W),
        .SEED  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .nummax_in (nummax_in),
        .en        (en),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .nummax    (nummax),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Visiting order of x^8+x^6+x^5+x^4+1 starting from the seed value 1.
    task automatic build_model();
        int s;
        int fb;
        s = 1;
        for (int i = 0; i < LEN; i++) begin
            seq[i] = s;
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s << 1) & 8'hFF) | fb;
        end
    endtask

    // mode: 0 en always high, 1 en toggles starting high, 2 en random.
    task automatic run_stream(input logic [W-1:0] v, input logic [8:0] nm, input int mode,
                              input int pulse_at, input int rst_at,
                              output int ones, output int nvalid, output int done_c);
        int  nlow;
        bit  exp_bit;
        ones = 0; nvalid = 0; nlow = 0; done_c = 0;
        start = 1'b1; value = v; nummax_in = nm; en = 1'b1;
        tick();
        start = 1'b0; value = W'($urandom); nummax_in = 9'($urandom);
        for (int c = 1; c <= 700; c++) begin
            if (c == pulse_at) begin
                start = 1'b1; value = ~v; nummax_in = ~nm;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       en = 1'b1;
                1:       en = (c % 2 == 1);
                default: en = ($urandom % 4 != 0);
            endcase
            if (rst_at >= 0 && nvalid == rst_at) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({bit_out, bit_valid, busy, done, nummax} !== 13'd0) begin
                    n_fail++;
                    $display("FAIL async_reset got out=%b vld=%b busy=%b done=%b nummax=%0d exp all 0",
                             bit_out, bit_valid, busy, done, nummax);
                end
                start = 1'b0;
                tick();
                rst_n = 1'b1;
                done_c = -1;
                return;
            end
            #1;
            if (nvalid == LEN) begin
                done_c = c;
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || bit_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_cycle c=%0d got done=%b busy=%b vld=%b exp 1,0,0", c, done, busy, bit_valid);
                end
                n_checks++;
                if (c != LEN + 1 + nlow) begin
                    n_fail++;
                    $display("FAIL done_latency got %0d exp %0d", c, LEN + 1 + nlow);
                end
                start = 1'b0;
                tick();
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0 || nummax !== nm) begin
                    n_fail++;
                    $display("FAIL after_done got done=%b busy=%b nummax=%0d exp 0,0,%0d", done, busy, nummax, nm);
                end
                return;
            end
            exp_bit = (seq[nvalid] <= int'(v));
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0 || bit_valid !== en || bit_out !== exp_bit || nummax !== nm) begin
                n_fail++;
                $display("FAIL run c=%0d bit%0d got busy=%b done=%b vld=%b out=%b nummax=%0d exp 1,0,%b,%b,%0d",
                         c, nvalid, busy, done, bit_valid, bit_out, nummax, en, exp_bit, nm);
            end
            if (en) begin
                if (nvalid < 5) g_first[nvalid] = bit_out;
                if (bit_out === 1'b1) ones++;
                nvalid++;
            end else begin
                nlow++;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout got no done after 700 cycles exp done");
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; value = '0; nummax_in = '0; en = 1'b0;
        #2;
        n_checks++;
        if ({bit_out, bit_valid, busy, done, nummax} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state got out=%b vld=%b busy=%b done=%b nummax=%0d exp all 0",
                     bit_out, bit_valid, busy, done, nummax);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lfsr_seq();
        int ones, nv, dc;
        logic exp_first [5];
        exp_first = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_stream(8'd3, 9'd17, 0, -1, -1, ones, nv, dc);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (g_first[i] !== exp_first[i]) begin
                n_fail++;
                $display("FAIL first_bits[%0d] got %b exp %b", i, g_first[i], exp_first[i]);
            end
        end
        check_count("ones_v3", ones, 3);
    endtask

    task automatic test_extremes();
        int ones, nv, dc;
        run_stream(8'd0, 9'd1, 0, -1, -1, ones, nv, dc);
        check_count("ones_v0", ones, 0);
        check_count("done_v0", dc, 256);
        run_stream(8'd255, 9'd511, 0, -1, -1, ones, nv, dc);
        check_count("ones_v255", ones, 255);
        check_count("done_v255", dc, 256);
    endtask

    task automatic test_nummax();
        int ones, nv, dc;
        run_stream(8'd128, 9'd200, 0, -1, -1, ones, nv, dc);
        check_count("ones_v128", ones, 128);
        check_count("valid_v128", nv, 255);
    endtask

    task automatic test_en_toggle();
        int ones, nv, dc;
        run_stream(8'd128, 9'd77, 1, -1, -1, ones, nv, dc);
        check_count("ones_toggle", ones, 128);
        check_count("valid_toggle", nv, 255);
        check_count("done_toggle", dc, 510);
    endtask

    task automatic test_start_ignored();
        int ones, nv, dc;
        run_stream(8'd40, 9'd300, 0, 50, -1, ones, nv, dc);
        check_count("ones_ignored_start", ones, 40);
    endtask

    task automatic test_reset_midstream();
        int ones, nv, dc;
        run_stream(8'd90, 9'd123, 0, -1, 100, ones, nv, dc);
        check_count("reset_at_bit", nv, 100);
        n_checks++;
        if (busy !== 1'b0 || nummax !== 9'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle got busy=%b nummax=%0d exp 0,0", busy, nummax);
        end
        run_stream(8'd90, 9'd123, 0, -1, -1, ones, nv, dc);
        check_count("ones_after_reset", ones, 90);
        check_count("valid_after_reset", nv, 255);
    endtask

    task automatic test_back_to_back_random();
        int ones, nv, dc;
        logic [W-1:0] v;
        logic [8:0]   nm;
        for (int i = 0; i < 4; i++) begin
            v  = W'($urandom);
            nm = 9'($urandom);
            run_stream(v, nm, 2, -1, -1, ones, nv, dc);
            check_count("ones_random", ones, int'(v));
            check_count("valid_random", nv, 255);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_lfsr_seq();
        test_extremes();
        test_nummax();
        test_en_toggle();
        test_start_ignored();
        test_reset_midstream();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
